// File: rtl/vec_mul_pkg.sv
// rtl/vec_mul_pkg.sv - shared state encoding and default sizes for the vector-multiply sequencer
//
// Purpose: state type for the sequencer FSM and the default address width and
//          datapath latency shared with the top level.
// Ports:   none (package).

package vec_mul_pkg;

   localparam int ADDRESSSIZE_DEF  = 10;
   localparam int PIPE_LATENCY_DEF = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      RELOAD = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } seq_state_t;

endpackage

// File: rtl/vec_mul_seq_delay.sv
// rtl/vec_mul_seq_delay.sv - valid delay line from unified-buffer read to results write
//
// Purpose: PIPE_LATENCY-deep shift register carrying the read-valid bit down to
//          the results-SRAM write enable, matching the datapath latency.
// Ports:   clk   - clock, rising edge
//          rstn  - asynchronous active-low reset, clears the line
//          flush - synchronous clear; the bit entering this cycle is dropped too
//          din   - read valid (ub_rd_en)
//          dout  - din delayed by PIPE_LATENCY cycles (res_wr_en)

module vec_mul_seq_delay
   import vec_mul_pkg::*;
#(
   parameter int PIPE_LATENCY = PIPE_LATENCY_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic flush,
   input  logic din,
   output logic dout
);

   logic [PIPE_LATENCY-1:0] sr_q;
   logic [PIPE_LATENCY-1:0] sr_d;

   // Shift toward the MSB; the truncating cast also covers PIPE_LATENCY=1.
   always_comb begin
      sr_d = sr_q;
      if (flush) begin
         sr_d = '0;
      end else begin
         sr_d = PIPE_LATENCY'({sr_q, din});
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[PIPE_LATENCY-1];

endmodule

// File: rtl/vec_mul_sequencer.sv
// rtl/vec_mul_sequencer.sv - start/done sequencer for one vector-multiply job
//
// Purpose: optionally pops a weight set and pulses weight_reload, streams N
//          unified-buffer reads, and issues the N matching results-SRAM writes
//          PIPE_LATENCY cycles later.
// Ports:   clk, rstn                   - clock, asynchronous active-low reset
//          start, reload_weights       - job request and weight-reload option
//          src_base, dst_base, vec_count - job parameters, sampled with start
//          abort                       - synchronous job cancel
//          fifo_empty                  - weight FIFO empty flag
//          fifo_read_enable, weight_reload - weight FIFO pop / array latch enable
//          ub_rd_en, ub_addr           - unified-buffer read
//          res_wr_en, res_addr         - results-SRAM write
//          busy, done, err             - status: not idle / completion / refused

module vec_mul_sequencer
   import vec_mul_pkg::*;
#(
   parameter int ADDRESSSIZE   = ADDRESSSIZE_DEF,
   parameter int PIPE_LATENCY  = PIPE_LATENCY_DEF,
   parameter int RELOAD_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   reload_weights,
   input  logic [ADDRESSSIZE-1:0] src_base,
   input  logic [ADDRESSSIZE-1:0] dst_base,
   input  logic [ADDRESSSIZE-1:0] vec_count,
   input  logic                   abort,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   weight_reload,
   output logic                   ub_rd_en,
   output logic [ADDRESSSIZE-1:0] ub_addr,
   output logic                   res_wr_en,
   output logic [ADDRESSSIZE-1:0] res_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam logic [ADDRESSSIZE-1:0] ONE     = ADDRESSSIZE'(1);
   localparam logic [ADDRESSSIZE-1:0] RL_LAST = ADDRESSSIZE'(RELOAD_CYCLES - 1);

   seq_state_t             state_q, state_d;
   logic [ADDRESSSIZE-1:0] n_q, n_d;
   logic [ADDRESSSIZE-1:0] cnt_q, cnt_d;        // reload cycles, then reads issued
   logic [ADDRESSSIZE-1:0] wr_cnt_q, wr_cnt_d;  // writes issued
   logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
   logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
   logic                   err_q, err_d;
   logic                   flush;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      wr_cnt_d   = wr_cnt_q;
      ub_addr_d  = ub_addr_q;
      res_addr_d = res_addr_q;
      err_d      = 1'b0;
      flush      = 1'b0;

      // Write-side bookkeeping runs off the delayed valid, independent of state.
      if (res_wr_en) begin
         res_addr_d = res_addr_q + ONE;
         wr_cnt_d   = wr_cnt_q + ONE;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (reload_weights && fifo_empty) begin
                  err_d = 1'b1;
               end else begin
                  n_d        = vec_count;
                  ub_addr_d  = src_base;
                  res_addr_d = dst_base;
                  cnt_d      = '0;
                  wr_cnt_d   = '0;
                  if (vec_count == '0) begin
                     state_d = DONE;
                  end else if (reload_weights) begin
                     state_d = LOAD_W;
                  end else begin
                     state_d = STREAM;
                  end
               end
            end
         end
         LOAD_W: begin
            cnt_d   = '0;
            state_d = RELOAD;
         end
         RELOAD: begin
            if (cnt_q == RL_LAST) begin
               cnt_d   = '0;
               state_d = STREAM;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         STREAM: begin
            ub_addr_d = ub_addr_q + ONE;
            cnt_d     = cnt_q + ONE;
            if (cnt_q == n_q - ONE) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (res_wr_en && (wr_cnt_q == n_q - ONE)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         flush   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         n_q        <= '0;
         cnt_q      <= '0;
         wr_cnt_q   <= '0;
         ub_addr_q  <= '0;
         res_addr_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         ub_addr_q  <= ub_addr_d;
         res_addr_q <= res_addr_d;
         err_q      <= err_d;
      end
   end

   vec_mul_seq_delay #(
      .PIPE_LATENCY(PIPE_LATENCY)
   ) u_delay (
      .clk  (clk),
      .rstn (rstn),
      .flush(flush),
      .din  (ub_rd_en),
      .dout (res_wr_en)
   );

   assign fifo_read_enable = (state_q == LOAD_W);
   assign weight_reload    = (state_q == RELOAD);
   assign ub_rd_en         = (state_q == STREAM);
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign err              = err_q;
   assign ub_addr          = ub_addr_q;
   assign res_addr         = res_addr_q;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// tb/tb_vec_mul_sequencer.sv - scoreboard bench for the vector-multiply sequencer

module tb_vec_mul_sequencer;

   localparam int A = 10;
   localparam int L = 3;
   localparam int R = 1;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic         reload_weights = 1'b0;
   logic [A-1:0] src_base = '0;
   logic [A-1:0] dst_base = '0;
   logic [A-1:0] vec_count = '0;
   logic         abort = 1'b0;
   logic         fifo_empty = 1'b0;
   logic         fifo_read_enable, weight_reload, ub_rd_en, res_wr_en;
   logic         busy, done, err;
   logic [A-1:0] ub_addr, res_addr;

   vec_mul_sequencer #(
      .ADDRESSSIZE  (A),
      .PIPE_LATENCY (L),
      .RELOAD_CYCLES(R)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .start           (start),
      .reload_weights  (reload_weights),
      .src_base        (src_base),
      .dst_base        (dst_base),
      .vec_count       (vec_count),
      .abort           (abort),
      .fifo_empty      (fifo_empty),
      .fifo_read_enable(fifo_read_enable),
      .weight_reload   (weight_reload),
      .ub_rd_en        (ub_rd_en),
      .ub_addr         (ub_addr),
      .res_wr_en       (res_wr_en),
      .res_addr        (res_addr),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   always #5 clk = ~clk;

   // Cycle k of a job (start sampled at edge 0) is observed at the negedge
   // where cyc == t0 + k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      logic [A-1:0] addr;
   } ev_t;

   // 0 fifo_read_enable, 1 weight_reload, 2 ub_rd_en, 3 res_wr_en, 4 done, 5 err, 6 busy
   ev_t   exp_q[7][$];
   string names[7] = '{"fifo_read_enable", "weight_reload", "ub_rd_en", "res_wr_en",
                       "done", "err", "busy"};
   int    tests = 0;
   int    fails = 0;

   task automatic push(input int k, input int t0, input int rel, input logic [A-1:0] a,
                       input int cut);
      ev_t e;
      if (rel < cut) begin
         e.cyc  = t0 + rel;
         e.addr = a;
         exp_q[k].push_back(e);
      end
   endtask

   // Expected events of one accepted job; events at relative cycle >= cut are
   // not expected (job cancelled by abort or reset at that point).
   task automatic expect_job(input int t0, input bit rw, input logic [A-1:0] s,
                             input logic [A-1:0] d, input logic [A-1:0] n, input int cut);
      int           b;
      logic [A-1:0] ra, wa;
      if (n == '0) begin
         push(4, t0, 1, '0, cut);
         push(6, t0, 1, '0, cut);
         return;
      end
      b = 1;
      if (rw) begin
         push(0, t0, 1, '0, cut);
         for (int c = 2; c <= R + 1; c++) push(1, t0, c, '0, cut);
         b = R + 2;
      end
      ra = s;
      wa = d;
      for (int i = 0; i < int'(n); i++) begin
         push(2, t0, b + i, ra, cut);
         ra = ra + 1'b1;
      end
      for (int i = 0; i < int'(n); i++) begin
         push(3, t0, b + i + L, wa, cut);
         wa = wa + 1'b1;
      end
      push(4, t0, b + int'(n) + L, '0, cut);
      for (int c = 1; c <= b + int'(n) + L; c++) push(6, t0, c, '0, cut);
   endtask

   // Monitor: every asserted output must match the head of its queue by cycle
   // and address; queue heads whose cycle has passed were missed.
   always @(negedge clk) begin
      logic [6:0]   act;
      logic [A-1:0] a;
      act = {busy, err, done, res_wr_en, ub_rd_en, weight_reload, fifo_read_enable};
      for (int k = 0; k < 7; k++) begin
         a = (k == 2) ? ub_addr : (k == 3) ? res_addr : '0;
         while (exp_q[k].size() > 0 && exp_q[k][0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL %s missed: actual 0 at cycle %0d, required 1", names[k],
                     exp_q[k][0].cyc);
            void'(exp_q[k].pop_front());
         end
         if (act[k]) begin
            tests++;
            if (exp_q[k].size() > 0 && exp_q[k][0].cyc == cyc) begin
               if (exp_q[k][0].addr !== a) begin
                  fails++;
                  $display("FAIL %s addr at cycle %0d: actual 0x%03h, required 0x%03h",
                           names[k], cyc, a, exp_q[k][0].addr);
               end
               void'(exp_q[k].pop_front());
            end else begin
               fails++;
               $display("FAIL %s unexpected: actual 1 at cycle %0d, required 0", names[k], cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_all_zero(input string tag);
      logic [2*A+7:0] v;
      v = {fifo_read_enable, weight_reload, ub_rd_en, ub_addr, res_wr_en, res_addr,
           busy, done, err};
      tests++;
      if (v !== '0) begin
         fails++;
         $display("FAIL %s outputs: actual 0x%0h, required 0", tag, v);
      end
   endtask

   // Drives start for exactly one edge; returns t0 and leaves the bench in cycle 1.
   task automatic start_job(input bit rw, input bit fe, input logic [A-1:0] s,
                            input logic [A-1:0] d, input logic [A-1:0] n, output int t0);
      start          = 1'b1;
      reload_weights = rw;
      fifo_empty     = fe;
      src_base       = s;
      dst_base       = d;
      vec_count      = n;
      t0             = cyc;
      tick();
      start          = 1'b0;
      reload_weights = 1'b0;
      fifo_empty     = 1'b0;
   endtask

   task automatic full_job(input bit rw, input logic [A-1:0] s, input logic [A-1:0] d,
                           input logic [A-1:0] n);
      int t0;
      expect_job(cyc, rw, s, d, n, 1000);
      start_job(rw, 1'b0, s, d, n, t0);
      ticks(14);
   endtask

   initial begin
      int t0;
      ticks(2);
      check_all_zero("reset");
      rstn = 1'b1;
      ticks(2);

      // 1: plain job, no reload
      full_job(1'b0, 10'h010, 10'h200, 10'd4);
      // 2: reload job
      full_job(1'b1, 10'h040, 10'h100, 10'd4);

      // 3: reload requested with empty FIFO: err only, cycle 1
      push(5, cyc, 1, '0, 1000);
      start_job(1'b1, 1'b1, 10'h055, 10'h066, 10'd4, t0);
      ticks(8);

      // 4: address wrap on both sides
      full_job(1'b0, 10'h3FE, 10'h3FF, 10'd4);

      // 5a: N=0 -> done in cycle 1, no enables
      full_job(1'b0, 10'h123, 10'h321, 10'd0);

      // 5b: start while busy (cycle 2) and start during done (cycle 8) ignored
      expect_job(cyc, 1'b0, 10'h010, 10'h200, 10'd4, 1000);
      start_job(1'b0, 1'b0, 10'h010, 10'h200, 10'd4, t0);
      tick();
      start = 1'b1; src_base = 10'h155; dst_base = 10'h2AA; vec_count = 10'd2;
      tick();
      start = 1'b0;
      ticks(5);
      start = 1'b1; src_base = 10'h0AA; dst_base = 10'h0BB; vec_count = 10'd3;
      tick();
      start = 1'b0;
      ticks(10);

      // 6a: abort during cycle 3 (sampled at edge 3): nothing from cycle 4 on
      expect_job(cyc, 1'b0, 10'h010, 10'h200, 10'd4, 4);
      start_job(1'b0, 1'b0, 10'h010, 10'h200, 10'd4, t0);
      ticks(2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      ticks(10);
      full_job(1'b0, 10'h010, 10'h200, 10'd4);

      // abort in IDLE has no effect
      abort = 1'b1;
      ticks(2);
      abort = 1'b0;
      ticks(2);

      // 6b: reset asserted in cycle 5: outputs clear immediately
      expect_job(cyc, 1'b0, 10'h010, 10'h200, 10'd4, 5);
      start_job(1'b0, 1'b0, 10'h010, 10'h200, 10'd4, t0);
      ticks(4);
      rstn = 1'b0;
      #1;
      check_all_zero("async_reset");
      ticks(2);
      rstn = 1'b1;
      ticks(2);
      full_job(1'b0, 10'h010, 10'h200, 10'd4);

      ticks(4);
      for (int k = 0; k < 7; k++) begin
         tests++;
         if (exp_q[k].size() != 0) begin
            fails++;
            $display("FAIL %s leftover: actual %0d pending, required 0", names[k],
                     exp_q[k].size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vec_mul_sequencer.md
Name: vec_mul_sequencer

Overview:
Control FSM that runs one vector-multiply job on the vector-multiply datapath. It optionally pops one weight set from the weight FIFO and pulses the array's weight_reload. It then streams N input vectors out of the unified buffer and writes N results into the results SRAM after the fixed datapath latency. It replaces the hand-driven valid_address, fifo_read_enable and weight_reload pins at the top level with a single start/done handshake.

Parameters:
ADDRESSSIZE, 10, address width of the unified buffer and the results SRAM
PIPE_LATENCY, 3, cycles from ub_rd_en asserted to the matching result appearing at the results SRAM data input (≥1)
RELOAD_CYCLES, 1, number of cycles weight_reload is held high (≥1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous, active-low reset
start  in  1  job request pulse; sampled only in IDLE
reload_weights  in  1  sampled with start; 1 = pop the FIFO and reload weights before streaming
src_base  in  ADDRESSSIZE  first unified-buffer address; sampled with start
dst_base  in  ADDRESSSIZE  first results-SRAM address; sampled with start
vec_count  in  ADDRESSSIZE  number of vectors N; sampled with start
abort  in  1  synchronous job cancel
fifo_empty  in  1  weight FIFO empty flag
fifo_read_enable  out  1  weight FIFO pop strobe
weight_reload  out  1  array weight-latch enable
ub_rd_en  out  1  unified-buffer read valid
ub_addr  out  ADDRESSSIZE  unified-buffer read address
res_wr_en  out  1  results-SRAM write enable
res_addr  out  ADDRESSSIZE  results-SRAM write address
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: job refused

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; every output and internal counter = 0; delay line cleared.
- States: IDLE, LOAD_W, RELOAD, STREAM, DRAIN, DONE.
- Cycle 0 is the clock edge at which start=1 is sampled in IDLE; cycle numbers below count edges from there.
- IDLE transitions on start:
  - reload_weights=1 and fifo_empty=1: err=1 in cycle 1, stay IDLE, nothing latched.
  - vec_count=0: go to DONE; done=1 in cycle 1; no enables asserted.
  - reload_weights=1: go to LOAD_W.
  - otherwise: go to STREAM.
- LOAD_W: lasts exactly 1 cycle with fifo_read_enable=1, then RELOAD.
- RELOAD: weight_reload=1 for RELOAD_CYCLES cycles, then STREAM.
- STREAM: ub_rd_en=1 for N consecutive cycles; ub_addr = src_base+i for i=0..N-1, wrapping modulo 2^ADDRESSSIZE. Go to DRAIN after the last read.
- Write path: res_wr_en is ub_rd_en delayed by exactly PIPE_LATENCY cycles through a shift register. res_addr = dst_base+j, with j counting accepted writes and wrapping modulo 2^ADDRESSSIZE.
- DRAIN: stay until the last res_wr_en has issued, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Timing with reload (R=RELOAD_CYCLES, L=PIPE_LATENCY):
  - fifo_read_enable in cycle 1
  - weight_reload in cycles 2..R+1
  - ub_rd_en in cycles R+2..R+1+N
  - res_wr_en in cycles R+2+L..R+1+N+L
  - done in cycle R+2+N+L
- Timing without reload:
  - ub_rd_en in cycles 1..N
  - res_wr_en in cycles 1+L..N+L
  - done in cycle N+L+1
- start while busy: ignored, with no err. start and done in the same cycle: start is ignored because the FSM is not yet in IDLE.
- abort (any non-IDLE state): next state IDLE; delay line flushed, so pending res_wr_en are dropped. No done, no err. abort in IDLE has no effect.
- fifo_empty is checked only at start; the FSM never stalls mid-job.
- When not valid, ub_addr and res_addr hold their last value. They are don't-care for checking while the matching enable is 0.
- Ranges: N max = 2^ADDRESSSIZE-1. Counters are ADDRESSSIZE bits wide; the delay line is PIPE_LATENCY bits wide.

Decomposition:
- Shared package vec_mul_pkg holds:
  - state encoding constants (IDLE=0, LOAD_W=1, RELOAD=2, STREAM=3, DRAIN=4, DONE=5; 3 bits)
  - default ADDRESSSIZE and PIPE_LATENCY values shared with the top level
- One sub-module, vec_mul_seq_delay: PIPE_LATENCY-deep valid shift register with synchronous flush and asynchronous active-low reset. It produces res_wr_en from ub_rd_en.

Test Plan:
1. L=3, reload_weights=0, src=0x010, dst=0x200, N=4, start in cycle 0 -> ub_rd_en cycles 1-4 with addresses 0x010-0x013; res_wr_en cycles 4-7 with addresses 0x200-0x203; done cycle 8; busy cycles 1-8.
2. R=1, L=3, reload_weights=1, fifo_empty=0, N=4 -> fifo_read_enable cycle 1; weight_reload cycle 2; ub_rd_en cycles 3-6; res_wr_en cycles 6-9; done cycle 10.
3. reload_weights=1, fifo_empty=1, start -> err=1 in cycle 1 only; busy stays 0; all enables stay 0.
4. src=0x3FE, dst=0x3FF, N=4 -> ub_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; res_addr sequence 0x3FF, 0x000, 0x001, 0x002.
5. N=0 -> done in cycle 1 and no enables; a second start while busy in test 1 (cycle 2) -> ignored, sequence unchanged.
6. abort in cycle 3 of test 1 -> IDLE in cycle 4; no res_wr_en after cycle 3, no done. Separately, rstn low in cycle 5 -> all outputs 0 immediately. In both cases a fresh start afterwards completes exactly as in test 1.
